// File: rtl/reg_arb.sv
// ---------------------------------------------------------------------------
// reg_arb -- two-requester arbiter in front of a single-port register file.
//
// Each transaction takes IDLE -> ACCESS -> RESP. The winner's command is
// latched when it is granted. ACCESS drives the register-file port. RESP
// returns a one-cycle ACK with ERR/RDATA. In RESP the other requester can be
// granted straight away, which gives one access every two cycles.
//
// Configuration macro: REG_ARB_RR_EN
//   defined   : round-robin arbitration between simultaneous requests
//   undefined : fixed priority, requester 0 wins simultaneous requests
//
// Ports
//   CLK, RST                    clock (rising edge), synchronous active-high reset
//   REQx, WEx, ADDRx, WDATAx    requester x command (x = 0, 1)
//   ACKx, ERRx, RDATAx          requester x response, valid for one cycle in RESP
//   RF_EN, RF_SEL, RF_IN        register-file write enable / index / write data
//   RF_OUT                      register-file read data (one-cycle latency)
//   BUSY                        high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module reg_arb #(
    parameter int WIDTH  = 8,
    parameter int SIZE   = 9,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [WIDTH-1:0]  WDATA0,
    input  logic              REQ1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [WIDTH-1:0]  WDATA1,
    output logic              ACK0,
    output logic              ERR0,
    output logic [WIDTH-1:0]  RDATA0,
    output logic              ACK1,
    output logic              ERR1,
    output logic [WIDTH-1:0]  RDATA1,
    output logic              RF_EN,
    output logic [ADDR_W-1:0] RF_SEL,
    output logic [WIDTH-1:0]  RF_IN,
    input  logic [WIDTH-1:0]  RF_OUT,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The last entry (SIZE-1) is the read-only IO port.
    localparam logic [ADDR_W:0]   SIZE_EXT = (ADDR_W + 1)'(SIZE);
    localparam logic [ADDR_W-1:0] IO_IDX   = ADDR_W'(SIZE - 1);

    state_t             state_reg;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [WIDTH-1:0]   wdata_reg;
    logic               winner_reg;
`ifdef REG_ARB_RR_EN
    // Holds the complement of the last winner: 1 means requester 0 won last,
    // so requester 1 is preferred next. Its cleared value prefers requester 0.
    logic               rr_ptr_reg;
`endif

    logic [1:0]         req_vec;
    logic [1:0]         elig_vec;
    logic               grant_valid;
    logic               grant_id;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic               legal;
    logic               in_access;
    logic               in_resp;
    logic [1:0]         ack_vec;
    logic [1:0]         err_vec;
    logic [WIDTH-1:0]   rdata_arr [2];

    assign req_vec   = {REQ1, REQ0};
    assign in_access = (state_reg == ACCESS);
    assign in_resp   = (state_reg == RESP);

    // A requester is eligible in IDLE, or in RESP unless it is the one being
    // acked right now (its REQ is still high during its own ACK cycle).
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
        assign elig_vec[gi] = req_vec[gi] &&
                              ((state_reg == IDLE) || (in_resp && (winner_reg != 1'(gi))));
    end

    assign grant_valid = |elig_vec;

    always_comb begin
        grant_id = 1'b0;
`ifdef REG_ARB_RR_EN
        if (elig_vec == 2'b11) begin
            grant_id = rr_ptr_reg;
        end else begin
            grant_id = elig_vec[1];
        end
`else
        grant_id = elig_vec[1] && !elig_vec[0];
`endif
    end

    assign sel_we    = grant_id ? WE1    : WE0;
    assign sel_addr  = grant_id ? ADDR1  : ADDR0;
    assign sel_wdata = grant_id ? WDATA1 : WDATA0;

    // Out-of-range index, or a write to the read-only IO entry.
    assign legal = ({1'b0, addr_reg} < SIZE_EXT) && !(we_reg && (addr_reg == IO_IDX));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            winner_reg <= 1'b0;
`ifdef REG_ARB_RR_EN
            rr_ptr_reg <= 1'b0;
`endif
        end else begin
            unique case (state_reg)
                IDLE, RESP: begin
                    if (grant_valid) begin
                        state_reg  <= ACCESS;
                        we_reg     <= sel_we;
                        addr_reg   <= sel_addr;
                        wdata_reg  <= sel_wdata;
                        winner_reg <= grant_id;
`ifdef REG_ARB_RR_EN
                        rr_ptr_reg <= ~grant_id;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ACCESS:  state_reg <= RESP;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Register-file side: only ACCESS drives the port. RST kills the write
    // combinationally so an aborted transaction never reaches the file.
    assign RF_EN  = in_access && we_reg && legal && !RST;
    assign RF_SEL = in_access ? addr_reg  : '0;
    assign RF_IN  = in_access ? wdata_reg : '0;
    assign BUSY   = (state_reg != IDLE);

    // Response side: RF_OUT already holds the value read during ACCESS.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign ack_vec[gi]   = in_resp && (winner_reg == 1'(gi)) && !RST;
        assign err_vec[gi]   = ack_vec[gi] && !legal;
        assign rdata_arr[gi] = (ack_vec[gi] && legal && !we_reg) ? RF_OUT : '0;
    end

    assign ACK0   = ack_vec[0];
    assign ERR0   = err_vec[0];
    assign RDATA0 = rdata_arr[0];
    assign ACK1   = ack_vec[1];
    assign ERR1   = err_vec[1];
    assign RDATA1 = rdata_arr[1];

endmodule

// File: tb/tb_reg_arb.sv
// ---------------------------------------------------------------------------
// tb_reg_arb -- self-checking bench for reg_arb.
// Directed scenarios, then randomized traffic checked against a transaction-
// level model: a reference copy of the register file, an access-legality rule
// and latency bounds. The register file itself is modelled behind RF_*.
// ---------------------------------------------------------------------------
module tb_reg_arb;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, WE0, REQ1, WE1;
    logic [3:0] ADDR0, ADDR1;
    logic [7:0] WDATA0, WDATA1;
    logic       ACK0, ERR0, ACK1, ERR1;
    logic [7:0] RDATA0, RDATA1;
    logic       RF_EN;
    logic [3:0] RF_SEL;
    logic [7:0] RF_IN;
    logic [7:0] RF_OUT;
    logic       BUSY;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  rf_mem  [16];
    logic [7:0]  ref_mem [16];
    logic        rf_ready = 1'b0;
    logic [33:0] all_outs;

    assign all_outs = {ACK0, ERR0, RDATA0, ACK1, ERR1, RDATA1, RF_EN, RF_SEL, RF_IN, BUSY};

    reg_arb #(.WIDTH(8), .SIZE(9), .ADDR_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
        .ACK0(ACK0), .ERR0(ERR0), .RDATA0(RDATA0),
        .ACK1(ACK1), .ERR1(ERR1), .RDATA1(RDATA1),
        .RF_EN(RF_EN), .RF_SEL(RF_SEL), .RF_IN(RF_IN), .RF_OUT(RF_OUT),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] init_val(input int i);
        return (i == 8) ? 8'h5C : 8'(8'h10 + i);
    endfunction

    // Register file: registered read of the pre-write contents.
    always @(posedge CLK) begin
        if (!rf_ready) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= init_val(i);
            rf_ready <= 1'b1;
            RF_OUT   <= 8'h00;
        end else begin
            if (RF_EN) rf_mem[RF_SEL] <= RF_IN;
            RF_OUT <= rf_mem[RF_SEL];
        end
    end

    function automatic bit illegal_access(input logic we, input logic [3:0] addr);
        return (addr >= 4'd9) || (we && (addr == 4'd8));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    // Single transaction from IDLE; reports latency in cycles (-1 = no ACK).
    task automatic solo_run(input bit id, input logic we, input logic [3:0] addr,
                            input logic [7:0] wd, output int lat, output logic err,
                            output logic [7:0] rd, output logic en_seen);
        lat = -1; err = 1'b0; rd = 8'h00; en_seen = 1'b0;
        tick();
        if (id) begin REQ1 = 1'b1; WE1 = we; ADDR1 = addr; WDATA1 = wd; end
        else    begin REQ0 = 1'b1; WE0 = we; ADDR0 = addr; WDATA0 = wd; end
        settle();
        for (int k = 0; k < 8; k++) begin
            en_seen = en_seen | RF_EN;
            if ((id ? ACK1 : ACK0) === 1'b1) begin
                lat = k;
                err = id ? ERR1 : ERR0;
                rd  = id ? RDATA1 : RDATA0;
                break;
            end
            tick();
            settle();
        end
        tick();
        REQ0 = 1'b0; REQ1 = 1'b0;
        settle();
    endtask

    // Both requesters issue reads in the same cycle; reports ACK cycle of each.
    task automatic pair_run(input logic [3:0] a0, input logic [3:0] a1,
                            output int t0, output int t1,
                            output logic [7:0] d0, output logic [7:0] d1);
        t0 = -1; t1 = -1; d0 = 8'h00; d1 = 8'h00;
        tick();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = a0;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = a1;
        settle();
        for (int k = 0; k < 12; k++) begin
            if (ACK0 === 1'b1 && t0 < 0) begin t0 = k; d0 = RDATA0; end
            if (ACK1 === 1'b1 && t1 < 0) begin t1 = k; d1 = RDATA1; end
            tick();
            if (t0 >= 0) REQ0 = 1'b0;
            if (t1 >= 0) REQ1 = 1'b0;
            settle();
            if (t0 >= 0 && t1 >= 0) break;
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
    endtask

    task automatic test_reset();
        tick(); RST = 1'b1; settle();
        n_cmp++;
        if (all_outs !== 34'd0) begin n_fail++; $display("FAIL rst_outs: got %h required 0", all_outs); end
        tick(); REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd4; WDATA0 = 8'h77; settle();
        tick(); settle();
        n_cmp++;
        if (all_outs !== 34'd0) begin n_fail++; $display("FAIL rst_hold_req: got %h required 0", all_outs); end
        tick(); RST = 1'b0; REQ0 = 1'b0; settle();
        n_cmp++;
        if (all_outs !== 34'd0) begin n_fail++; $display("FAIL rst_release: got %h required 0", all_outs); end
        tick(); settle();
        n_cmp++;
        if (all_outs !== 34'd0) begin n_fail++; $display("FAIL rst_idle: got %h required 0", all_outs); end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_write_read();
        tick(); REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd3; WDATA0 = 8'hA5; settle();
        n_cmp++;
        if (BUSY !== 1'b0 || ACK0 !== 1'b0) begin n_fail++; $display("FAIL wr_idle: busy=%b ack0=%b required 0/0", BUSY, ACK0); end
        tick(); settle();
        n_cmp++;
        if ({RF_EN, RF_SEL, RF_IN, BUSY} !== {1'b1, 4'd3, 8'hA5, 1'b1})
        begin n_fail++; $display("FAIL wr_access: en=%b sel=%0d in=%h busy=%b required 1/3/a5/1", RF_EN, RF_SEL, RF_IN, BUSY); end
        tick(); settle();
        n_cmp++;
        if ({ACK0, ERR0, RDATA0, RF_EN, ACK1} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
        begin n_fail++; $display("FAIL wr_resp: ack0=%b err0=%b rdata0=%h en=%b ack1=%b required 1/0/00/0/0", ACK0, ERR0, RDATA0, RF_EN, ACK1); end
        ref_mem[3] = 8'hA5;
        tick(); REQ0 = 1'b0; REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 4'd3; settle();
        n_cmp++;
        if (ACK0 !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL rd_idle: ack0=%b busy=%b required 0/0", ACK0, BUSY); end
        tick(); settle();
        n_cmp++;
        if ({RF_EN, RF_SEL} !== {1'b0, 4'd3}) begin n_fail++; $display("FAIL rd_access: en=%b sel=%0d required 0/3", RF_EN, RF_SEL); end
        tick(); settle();
        n_cmp++;
        if ({ACK1, ERR1, RDATA1, ACK0} !== {1'b1, 1'b0, 8'hA5, 1'b0})
        begin n_fail++; $display("FAIL rd_resp: ack1=%b err1=%b rdata1=%h ack0=%b required 1/0/a5/0", ACK1, ERR1, RDATA1, ACK0); end
        tick(); REQ1 = 1'b0; settle();
        $display("test_write_read done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_simultaneous();
        int t0, t1, lat, exp_t0, exp_t1;
        logic [7:0] d0, d1, rd;
        logic e, en;
        tick(); RST = 1'b1; settle();
        tick(); RST = 1'b0; settle();
        pair_run(4'd5, 4'd6, t0, t1, d0, d1);
        n_cmp++;
        if (t0 != 2 || t1 != 4) begin n_fail++; $display("FAIL pair1_timing: ack0@%0d ack1@%0d required 2/4", t0, t1); end
        n_cmp++;
        if (d0 !== ref_mem[5] || d1 !== ref_mem[6])
        begin n_fail++; $display("FAIL pair1_data: %h/%h required %h/%h", d0, d1, ref_mem[5], ref_mem[6]); end
        solo_run(1'b0, 1'b0, 4'd1, 8'h00, lat, e, rd, en);
        n_cmp++;
        if (lat != 2 || e !== 1'b0 || rd !== ref_mem[1])
        begin n_fail++; $display("FAIL solo_rd: lat=%0d err=%b rd=%h required 2/0/%h", lat, e, rd, ref_mem[1]); end
`ifdef REG_ARB_RR_EN
        exp_t0 = 4; exp_t1 = 2;
`else
        exp_t0 = 2; exp_t1 = 4;
`endif
        pair_run(4'd5, 4'd6, t0, t1, d0, d1);
        n_cmp++;
        if (t0 != exp_t0 || t1 != exp_t1)
        begin n_fail++; $display("FAIL pair2_timing: ack0@%0d ack1@%0d required %0d/%0d", t0, t1, exp_t0, exp_t1); end
        $display("test_simultaneous done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_illegal();
        logic       we_t   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] addr_t [6] = '{4'd8, 4'd9, 4'd8, 4'd12, 4'd7, 4'd7};
        logic [7:0] wd_t   [6] = '{8'h99, 8'h00, 8'h00, 8'h66, 8'h3E, 8'h00};
        int lat;
        logic e, en, exp_e, exp_en;
        logic [7:0] rd, exp_rd;
        for (int i = 0; i < 6; i++) begin
            exp_e  = illegal_access(we_t[i], addr_t[i]);
            exp_rd = (!exp_e && !we_t[i]) ? ref_mem[addr_t[i]] : 8'h00;
            exp_en = we_t[i] && !exp_e;
            solo_run(1'(i % 2), we_t[i], addr_t[i], wd_t[i], lat, e, rd, en);
            n_cmp++;
            if (lat != 2 || e !== exp_e || rd !== exp_rd || en !== exp_en)
            begin n_fail++; $display("FAIL legality_%0d: lat=%0d err=%b rd=%h en=%b required 2/%b/%h/%b", i, lat, e, rd, en, exp_e, exp_rd, exp_en); end
            if (exp_en) ref_mem[addr_t[i]] = wd_t[i];
        end
        $display("test_illegal done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_fairness();
        int last_id = -1, last_t = -1, first_t = -1, n0 = 0, n1 = 0, id;
        bit ack0_now;
        tick();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 4'd1;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 4'd2;
        settle();
        for (int k = 0; k < 22; k++) begin
            ack0_now = (ACK0 === 1'b1);
            if (ACK0 === 1'b1 && ACK1 === 1'b1) begin
                n_cmp++; n_fail++; $display("FAIL fair_dual_ack: both ACKs at k=%0d required one", k);
            end else if (ACK0 === 1'b1 || ACK1 === 1'b1) begin
                id = (ACK1 === 1'b1) ? 1 : 0;
                if (first_t < 0) first_t = k;
                if (last_id >= 0) begin
                    n_cmp++;
                    if (id == last_id || k - last_t != 2)
                    begin n_fail++; $display("FAIL fair_alt: ack%0d at k=%0d after ack%0d at k=%0d required other id 2 later", id, k, last_id, last_t); end
                end
                last_id = id; last_t = k;
                if (id == 0) n0++; else n1++;
            end
            tick();
            REQ0 = ack0_now ? 1'b0 : 1'b1;
            settle();
        end
        tick(); REQ0 = 1'b0; REQ1 = 1'b0; settle();
        for (int k = 0; k < 4; k++) begin tick(); settle(); end
        n_cmp++;
        if (first_t != 2 || n0 != 5 || n1 != 5)
        begin n_fail++; $display("FAIL fair_count: first=%0d n0=%0d n1=%0d required 2/5/5", first_t, n0, n1); end
        $display("test_fairness done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_reset_abort();
        int lat;
        logic e, en;
        logic [7:0] rd;
        tick(); REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd2; WDATA0 = 8'hC3; settle();
        tick(); RST = 1'b1; settle();
        n_cmp++;
        if (RF_EN !== 1'b0 || ACK0 !== 1'b0) begin n_fail++; $display("FAIL abort_access: en=%b ack0=%b required 0/0", RF_EN, ACK0); end
        tick(); RST = 1'b0; REQ0 = 1'b0; settle();
        n_cmp++;
        if (BUSY !== 1'b0 || all_outs !== 34'd0) begin n_fail++; $display("FAIL abort_after: outs=%h required 0", all_outs); end
        tick(); settle();
        n_cmp++;
        if (all_outs !== 34'd0) begin n_fail++; $display("FAIL abort_no_ack: outs=%h required 0", all_outs); end
        n_cmp++;
        if (rf_mem[2] !== ref_mem[2]) begin n_fail++; $display("FAIL abort_mem: entry2=%h required %h", rf_mem[2], ref_mem[2]); end
        tick(); REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 4'd4; settle();
        tick(); settle();
        tick(); RST = 1'b1; settle();
        n_cmp++;
        if (ACK1 !== 1'b0 || RDATA1 !== 8'h00) begin n_fail++; $display("FAIL abort_resp: ack1=%b rdata1=%h required 0/00", ACK1, RDATA1); end
        tick(); RST = 1'b0; REQ1 = 1'b0; settle();
        n_cmp++;
        if (all_outs !== 34'd0) begin n_fail++; $display("FAIL abort_resp_after: outs=%h required 0", all_outs); end
        solo_run(1'b1, 1'b0, 4'd4, 8'h00, lat, e, rd, en);
        n_cmp++;
        if (lat != 2 || e !== 1'b0 || rd !== ref_mem[4])
        begin n_fail++; $display("FAIL abort_reissue: lat=%0d err=%b rd=%h required 2/0/%h", lat, e, rd, ref_mem[4]); end
        $display("test_reset_abort done: compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_random();
        bit         pend  [2] = '{1'b0, 1'b0};
        bit         cool  [2] = '{1'b0, 1'b0};
        logic       rwe   [2] = '{1'b0, 1'b0};
        logic [3:0] raddr [2] = '{4'd0, 4'd0};
        logic [7:0] rwd   [2] = '{8'h00, 8'h00};
        int         issue [2] = '{0, 0};
        int last_ack = -10, lat, n_tx = 0;
        logic a, e, exp_e;
        logic [7:0] d, exp_d;
        for (int c = 0; c < 300; c++) begin
            tick();
            for (int x = 0; x < 2; x++) begin
                if (cool[x]) cool[x] = 1'b0;
                else if (!pend[x] && c < 290 && $urandom_range(0, 2) == 0) begin
                    pend[x]  = 1'b1;
                    rwe[x]   = 1'($urandom_range(0, 1));
                    raddr[x] = 4'($urandom_range(0, 11));
                    rwd[x]   = 8'($urandom);
                    issue[x] = c;
                end
            end
            REQ0 = pend[0]; WE0 = rwe[0]; ADDR0 = raddr[0]; WDATA0 = rwd[0];
            REQ1 = pend[1]; WE1 = rwe[1]; ADDR1 = raddr[1]; WDATA1 = rwd[1];
            settle();
            if (ACK0 === 1'b1 && ACK1 === 1'b1) begin
                n_cmp++; n_fail++; $display("FAIL rnd_dual_ack: cycle %0d", c);
            end
            for (int x = 0; x < 2; x++) begin
                a = (x == 1) ? ACK1 : ACK0;
                e = (x == 1) ? ERR1 : ERR0;
                d = (x == 1) ? RDATA1 : RDATA0;
                if (a === 1'b1) begin
                    n_cmp++;
                    if (!pend[x]) begin
                        n_fail++; $display("FAIL rnd_unexpected_ack%0d: cycle %0d with no request", x, c);
                    end else begin
                        exp_e = illegal_access(rwe[x], raddr[x]);
                        exp_d = (!exp_e && !rwe[x]) ? ref_mem[raddr[x]] : 8'h00;
                        lat   = c - issue[x];
                        if (e !== exp_e || d !== exp_d || lat < 2 || lat > 4 || c - last_ack < 2)
                        begin n_fail++; $display("FAIL rnd_tx%0d: we=%b addr=%0d err=%b rd=%h lat=%0d required err=%b rd=%h lat 2..4", x, rwe[x], raddr[x], e, d, lat, exp_e, exp_d); end
                        if (!exp_e && rwe[x]) ref_mem[raddr[x]] = rwd[x];
                        pend[x] = 1'b0; cool[x] = 1'b1; last_ack = c; n_tx++;
                    end
                end else if (pend[x] && c - issue[x] > 4) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rnd_timeout%0d: no ACK %0d cycles after request", x, c - issue[x]);
                    pend[x] = 1'b0; cool[x] = 1'b1;
                end
            end
            if (ACK0 !== 1'b1 && ACK1 !== 1'b1) begin
                n_cmp++;
                if ({ERR0, ERR1, RDATA0, RDATA1} !== 18'd0)
                begin n_fail++; $display("FAIL rnd_quiet: err=%b%b rdata=%h/%h required 0", ERR0, ERR1, RDATA0, RDATA1); end
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        $display("test_random done: transactions=%0d compared=%0d mismatched=%0d", n_tx, n_cmp, n_fail);
    endtask

    initial begin
        RST = 1'b1;
        REQ0 = 1'b0; WE0 = 1'b0; ADDR0 = 4'd0; WDATA0 = 8'h00;
        REQ1 = 1'b0; WE1 = 1'b0; ADDR1 = 4'd0; WDATA1 = 8'h00;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_write_read();
        test_simultaneous();
        test_illegal();
        test_fairness();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_arb.md
REG_ARB -- requirements
Module: reg_arb

Interface
REQ-001 The parameters SHALL be: WIDTH, 8, data width; SIZE, 9, register-file entries (index SIZE-1 = IO port entry); ADDR_W, 4, address width.
REQ-002 The clock and reset ports SHALL be: CLK  in  1  clock, rising edge; RST  in  1  synchronous active-high reset.
REQ-003 The requester 0 ports SHALL be: REQ0  in  1  request; WE0  in  1  write (1) / read (0); ADDR0  in  ADDR_W  register index; WDATA0  in  WIDTH  write data.
REQ-004 Requester 1 SHALL have the same four input ports, suffixed 1.
REQ-005 The response ports for requester x (x=0,1) SHALL be: ACKx  out  1  one-cycle completion pulse; ERRx  out  1  error, valid with ACKx; RDATAx  out  WIDTH  read data, valid with ACKx.
REQ-006 The register-file side ports SHALL be: RF_EN  out  1  write enable; RF_SEL  out  ADDR_W  index; RF_IN  out  WIDTH  write data; RF_OUT  in  WIDTH  registered read data, one-cycle latency, reflecting pre-write contents.
REQ-007 The status port SHALL be: BUSY  out  1  high when state is not IDLE.

Function
REQ-008 The FSM SHALL have three states, IDLE, ACCESS and RESP, and transactions SHALL NOT overlap.
REQ-009 In IDLE (or in RESP, see REQ-014), any eligible REQx SHALL select a winner, latch its WE/ADDR/WDATA and winner id, and enter ACCESS at the next edge.
REQ-010 In ACCESS, RF_SEL SHALL equal the latched ADDR; RF_IN SHALL equal the latched WDATA; RF_EN SHALL equal latched WE & legal & !RST; the next state SHALL be RESP.
REQ-011 An ACCESS SHALL be illegal when ADDR >= SIZE, or when WE=1 and ADDR == SIZE-1 (the read-only IO port entry).
REQ-012 An illegal access SHALL NOT assert RF_EN.
REQ-013 In RESP, the arbiter SHALL pulse ACK of the winner for exactly one cycle, with RDATA = RF_OUT for a legal read and 0 for a write or an illegal access, and ERR = 1 if and only if the access was illegal.
REQ-014 In RESP, the just-acked requester SHALL be masked from arbitration. A pending REQ from the other requester SHALL go directly to ACCESS; otherwise the next state SHALL be IDLE.
REQ-015 Peak throughput SHALL be one access per 2 cycles; the latency from a REQ seen in IDLE to its ACK SHALL be 2 cycles.
REQ-016 A requester SHALL hold REQ/WE/ADDR/WDATA stable until its ACK and drop REQ in the cycle after its ACK. The inputs SHALL be ignored after latching.
REQ-017 When both requesters request in the same cycle, the winner SHALL be chosen per REQ-024/REQ-025. The loser SHALL keep REQ high and be served next (2 cycles later).
REQ-018 Outside ACCESS, RF_EN SHALL be 0 and RF_SEL/RF_IN SHALL be 0.
REQ-019 Outside RESP, ACKx, ERRx and RDATAx SHALL be 0.

Reset
REQ-020 While RST is high at an edge, the FSM SHALL go to IDLE, and all latched command fields, the winner id and the round-robin pointer SHALL clear to 0.
REQ-021 After reset, every output SHALL be 0 (ACKx, ERRx, RDATAx, RF_EN, RF_SEL, RF_IN, BUSY).
REQ-022 A RST asserted during ACCESS SHALL suppress RF_EN in that cycle (no write), and no ACK SHALL be issued for the aborted transaction.
REQ-023 A RST asserted during RESP SHALL suppress the pending ACK, and the requester SHALL re-issue its request.

Configuration
REQ-024 With macro REG_ARB_RR_EN defined, the arbiter SHALL use round-robin arbitration: a 1-bit pointer records the last winner, a simultaneous request is granted to the requester that did not win last, and the pointer updates on each grant; after reset, requester 0 is preferred.
REQ-025 With REG_ARB_RR_EN undefined, the arbiter SHALL use fixed priority, with requester 0 always winning simultaneous requests, and SHALL contain no pointer register.

Verification
REQ-026 The bench SHALL cover: REQ0 write ADDR0=3, WDATA0=0xA5 in IDLE -> RF_EN=1, RF_SEL=3, RF_IN=0xA5 in the next cycle, then ACK0=1, ERR0=0, RDATA0=0 one cycle later.
REQ-027 The bench SHALL cover: REQ1 read ADDR1=3 after REQ-026, with RF_OUT=0xA5 -> ACK1=1, RDATA1=0xA5, 2 cycles after REQ1.
REQ-028 The bench SHALL cover: REQ0 and REQ1 asserted together from reset -> ACK0 at +2 and ACK1 at +4 under both configurations; with REG_ARB_RR_EN defined, a second simultaneous pair -> ACK1 first.
REQ-029 The bench SHALL cover: REQ0 write ADDR0=8 and REQ0 read ADDR0=9 -> RF_EN stays 0, ACK0=1 with ERR0=1, RDATA0=0; REQ0 read ADDR0=8 -> ERR0=0, RDATA0=RF_OUT.
REQ-030 The bench SHALL cover: RST asserted in the ACCESS cycle of a write to ADDR=2 -> RF_EN=0 that cycle, no ACK, BUSY=0 on the next cycle, all outputs 0.
REQ-031 The bench SHALL cover: REQ1 held continuously while REQ0 is re-issued immediately after each ACK0, with REG_ARB_RR_EN defined -> ACK0 and ACK1 alternate with no requester starved.
